// File: rtl/pe_array_drain.sv
// pe_array_drain: sweeps PE-group accumulation buffers and streams the words on valid/ready.
// Optional stall counter is built when PE_DRAIN_PERF_EN is defined; otherwise stall_cnt is tied to 0.
module pe_array_drain #(
  parameter int PE_NUM     = 32,
  parameter int BUF_DEPTH  = 256,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int OUT_W      = 64,
  localparam int GRP_NUM   = PE_NUM / 4,
  localparam int GW        = $clog2(GRP_NUM),
  localparam int ADDR_W    = $clog2(BUF_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [GW:0]       grp_cnt,
  input  logic [ADDR_W:0]   addr_cnt,
  output logic              busy,
  output logic              done,
  output logic [GW-1:0]     rd_sel,
  output logic [ADDR_W-1:0] abuf_rd_addr,
  input  logic [OUT_W-1:0]  abuf_rd_data,
  output logic [OUT_W-1:0]  out_data,
  output logic [GW-1:0]     out_grp,
  output logic              out_grp_last,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       stall_cnt
);

  localparam int TAG_W = GW + 2;
  localparam int ENT_W = OUT_W + TAG_W;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(FIFO_DEPTH + RD_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, FLUSH, DONE} state_t;
  state_t state;

  logic [GW:0]      grp_cnt_l;
  logic [ADDR_W:0]  addr_cnt_l;
  logic             tag_grp_last, tag_last, issue;
  logic [CW-1:0]    fifo_count, inflight;
  logic             pipe_v   [RD_LAT];
  logic [TAG_W-1:0] pipe_tag [RD_LAT];
  logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             push, pop;
  logic [ENT_W-1:0] head;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RD_LAT; i++) inflight = inflight + CW'(pipe_v[i]);
  end

  // rd_sel/abuf_rd_addr double as the issue counters g/a
  assign tag_grp_last = ({1'b0, abuf_rd_addr} == addr_cnt_l - (ADDR_W+1)'(1));
  assign tag_last     = tag_grp_last && ({1'b0, rd_sel} == grp_cnt_l - (GW+1)'(1));
  assign issue        = (state == ISSUE) && ((fifo_count + inflight) < CW'(FIFO_DEPTH));

  assign push = pipe_v[RD_LAT-1];
  assign pop  = out_valid && out_ready;
  assign head = fifo_mem[rd_ptr];

  assign out_valid    = (fifo_count != '0);
  assign out_data     = out_valid ? head[ENT_W-1 -: OUT_W] : '0;
  assign out_grp      = out_valid ? head[TAG_W-1:2] : '0;
  assign out_grp_last = out_valid && head[1];
  assign out_last     = out_valid && head[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < RD_LAT; i++) pipe_v[i] <= 1'b0;
    end else begin
      pipe_v[0] <= issue;
      for (int unsigned i = 1; i < RD_LAT; i++) pipe_v[i] <= pipe_v[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pipe_tag[0] <= {rd_sel, tag_grp_last, tag_last};
    for (int unsigned i = 1; i < RD_LAT; i++) pipe_tag[i] <= pipe_tag[i-1];
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {abuf_rd_data, pipe_tag[RD_LAT-1]};
  end

  // pointers wrap naturally, so FIFO_DEPTH is expected to be a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      rd_sel       <= '0;
      abuf_rd_addr <= '0;
      grp_cnt_l    <= '0;
      addr_cnt_l   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy         <= 1'b1;
            grp_cnt_l    <= grp_cnt;
            addr_cnt_l   <= addr_cnt;
            rd_sel       <= '0;
            abuf_rd_addr <= '0;
            if (grp_cnt != '0 && addr_cnt != '0) begin
              state <= ISSUE;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (issue) begin
            if (tag_last) begin
              state <= FLUSH;
            end else if (tag_grp_last) begin
              abuf_rd_addr <= '0;
              rd_sel       <= rd_sel + GW'(1);
            end else begin
              abuf_rd_addr <= abuf_rd_addr + ADDR_W'(1);
            end
          end
        end
        FLUSH: begin
          // look ahead one pop so done lands the cycle right after the final beat
          if (inflight == '0 && (fifo_count == '0 || (fifo_count == CW'(1) && pop))) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PE_DRAIN_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (state == IDLE && start) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pe_array_drain.sv
// Directed bench for pe_array_drain: behavioural accum-buffer model with RD_LAT=2 and a beat monitor.
module tb_pe_array_drain;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  grp_cnt = '0;
  logic [8:0]  addr_cnt = '0;
  logic        busy, done;
  logic [2:0]  rd_sel;
  logic [7:0]  abuf_rd_addr;
  logic [63:0] abuf_rd_data;
  logic [63:0] out_data;
  logic [2:0]  out_grp;
  logic        out_grp_last, out_last, out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] stall_cnt;

  typedef logic [68:0] beat_t;
  beat_t q[$];
  int checks = 0;
  int errors = 0;
  int stalls = 0;
  int ready_mode = 0;
  int rcnt = 0;
  logic [10:0] p1, p2;

  always #5 clk = ~clk;

  pe_array_drain #(.PE_NUM(32), .BUF_DEPTH(256), .RD_LAT(2), .FIFO_DEPTH(8), .OUT_W(64)) dut (
    .clk(clk), .rst(rst), .start(start), .grp_cnt(grp_cnt), .addr_cnt(addr_cnt),
    .busy(busy), .done(done), .rd_sel(rd_sel), .abuf_rd_addr(abuf_rd_addr),
    .abuf_rd_data(abuf_rd_data), .out_data(out_data), .out_grp(out_grp),
    .out_grp_last(out_grp_last), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .stall_cnt(stall_cnt)
  );

  function automatic logic [63:0] mem_val(input logic [2:0] g, input logic [7:0] a);
    logic [15:0] w;
    w = {5'd0, g, a};
    return {w, ~w, w ^ 16'h5A5A, w + 16'h1234};
  endfunction

  // accumulation buffer: data appears two cycles after the address is presented
  always @(posedge clk) begin
    p1 <= {rd_sel, abuf_rd_addr};
    p2 <= p1;
  end
  assign abuf_rd_data = mem_val(p2[10:8], p2[7:0]);

  always @(posedge clk) begin
    #1;
    rcnt = rcnt + 1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (rcnt % 3 == 0);
      default: out_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (out_valid && out_ready) q.push_back({out_data, out_grp, out_grp_last, out_last});
    if (out_valid && !out_ready) stalls++;
  end

  task automatic do_start(input int g, input int a);
    @(posedge clk); #1;
    q.delete();
    stalls = 0;
    start = 1'b1;
    grp_cnt = 4'(g);
    addr_cnt = 9'(a);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok, output int n);
    ok = 1'b0;
    n = 0;
    while (!ok && n < limit) begin
      @(negedge clk);
      if (done) ok = 1'b1;
      else n++;
    end
  endtask

  task automatic test_reset;
    logic [127:0] obs;
    @(negedge clk);
    obs = {busy, done, rd_sel, abuf_rd_addr, out_valid, out_last, out_grp_last, out_grp, out_data, stall_cnt};
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_in got %h exp 0", obs); end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    obs = {busy, done, rd_sel, abuf_rd_addr, out_valid, out_last, out_grp_last, out_grp, out_data, stall_cnt};
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_out got %h exp 0", obs); end
  endtask

  task automatic test_single_group;
    logic [8:0] ov, dn, bz;
    beat_t exp, obs;
    ready_mode = 0;
    do_start(1, 4);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      ov[i] = out_valid; dn[i] = done; bz[i] = busy;
    end
    checks++;
    if (ov !== 9'b0_0111_1000) begin errors++; $display("FAIL t1_valid_timing got %b exp %b", ov, 9'b0_0111_1000); end
    checks++;
    if (dn !== 9'b0_1000_0000) begin errors++; $display("FAIL t1_done_timing got %b exp %b", dn, 9'b0_1000_0000); end
    checks++;
    if (bz !== 9'b0_1111_1111) begin errors++; $display("FAIL t1_busy_timing got %b exp %b", bz, 9'b0_1111_1111); end
    checks++;
    if (q.size() != 4) begin errors++; $display("FAIL t1_count got %0d exp 4", q.size()); end
    for (int i = 0; i < 4; i++) begin
      exp = {mem_val(3'd0, 8'(i)), 3'd0, 1'(i == 3), 1'(i == 3)};
      obs = (i < q.size()) ? q[i] : 'x;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL t1_beat%0d got %h exp %h", i, obs, exp); end
    end
  endtask

  task automatic test_full_sweep;
    bit ok;
    int n, g, a;
    beat_t exp, obs;
    ready_mode = 0;
    do_start(8, 256);
    wait_done(3000, ok, n);
    checks++;
    if (!ok) begin errors++; $display("FAIL t2_done_timeout got 0 exp 1"); end
    checks++;
    if (n != 2051) begin errors++; $display("FAIL t2_done_cycle got %0d exp 2051", n); end
    checks++;
    if (q.size() != 2048) begin errors++; $display("FAIL t2_count got %0d exp 2048", q.size()); end
    for (int i = 0; i < 2048; i++) begin
      g = i / 256; a = i % 256;
      exp = {mem_val(3'(g), 8'(a)), 3'(g), 1'(a == 255), 1'(a == 255 && g == 7)};
      obs = (i < q.size()) ? q[i] : 'x;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL t2_beat%0d got %h exp %h", i, obs, exp); end
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    int n, g, a;
    beat_t exp, obs;
    logic [31:0] exp_stall;
    ready_mode = 1;
    do_start(2, 16);
    wait_done(1000, ok, n);
    checks++;
    if (!ok) begin errors++; $display("FAIL t3_done_timeout got 0 exp 1"); end
    checks++;
    if (q.size() != 32) begin errors++; $display("FAIL t3_count got %0d exp 32", q.size()); end
    for (int i = 0; i < 32; i++) begin
      g = i / 16; a = i % 16;
      exp = {mem_val(3'(g), 8'(a)), 3'(g), 1'(a == 15), 1'(a == 15 && g == 1)};
      obs = (i < q.size()) ? q[i] : 'x;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL t3_beat%0d got %h exp %h", i, obs, exp); end
    end
`ifdef PE_DRAIN_PERF_EN
    exp_stall = 32'(stalls);
`else
    exp_stall = '0;
`endif
    checks++;
    if (stall_cnt !== exp_stall) begin errors++; $display("FAIL t3_stall_cnt got %0d exp %0d", stall_cnt, exp_stall); end
    ready_mode = 0;
  endtask

  task automatic test_zero_count;
    bit seen;
    ready_mode = 0;
    @(posedge clk); #1;
    q.delete();
    start = 1'b1; grp_cnt = 4'd0; addr_cnt = 9'd4;
    @(posedge clk); #1;
    grp_cnt = 4'd1;
    @(negedge clk);
    checks++;
    if ({busy, done, out_valid} !== 3'b110) begin errors++; $display("FAIL t4_g0_first got %b exp 110", {busy, done, out_valid}); end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin errors++; $display("FAIL t4_g0_second got %b exp 00", {busy, done}); end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy || out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || q.size() != 0) begin errors++; $display("FAIL t4_busy_start_ignored got %b/%0d exp 0/0", seen, q.size()); end
    checks++;
    if (stall_cnt !== 32'd0) begin errors++; $display("FAIL t4_stall_clear got %0d exp 0", stall_cnt); end
    do_start(1, 0);
    @(negedge clk);
    checks++;
    if ({busy, done, out_valid} !== 3'b110) begin errors++; $display("FAIL t4_a0_first got %b exp 110", {busy, done, out_valid}); end
    repeat (6) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || q.size() != 0) begin errors++; $display("FAIL t4_a0_after got %b/%0d exp 0/0", busy, q.size()); end
  endtask

  task automatic test_reset_mid_drain;
    logic [127:0] obs0;
    bit ok, seen;
    int n, g, a;
    beat_t exp, obs;
    ready_mode = 0;
    do_start(2, 32);
    repeat (8) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== mem_val(3'd0, 8'd4)) begin
      errors++; $display("FAIL t5_beat5 got %b/%h exp 1/%h", out_valid, out_data, mem_val(3'd0, 8'd4));
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    obs0 = {busy, done, rd_sel, abuf_rd_addr, out_valid, out_last, out_grp_last, out_grp, out_data, stall_cnt};
    checks++;
    if (obs0 !== '0) begin errors++; $display("FAIL t5_reset_zero got %h exp 0", obs0); end
    checks++;
    if (q.size() != 5) begin errors++; $display("FAIL t5_pre_reset_beats got %0d exp 5", q.size()); end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy || out_valid || done) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL t5_inflight_dropped got %b exp 0", seen); end
    do_start(2, 32);
    wait_done(500, ok, n);
    checks++;
    if (!ok) begin errors++; $display("FAIL t5_done_timeout got 0 exp 1"); end
    checks++;
    if (q.size() != 64) begin errors++; $display("FAIL t5_count got %0d exp 64", q.size()); end
    for (int i = 0; i < 64; i++) begin
      g = i / 32; a = i % 32;
      exp = {mem_val(3'(g), 8'(a)), 3'(g), 1'(a == 31), 1'(a == 31 && g == 1)};
      obs = (i < q.size()) ? q[i] : 'x;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL t5_beat%0d got %h exp %h", i, obs, exp); end
    end
  endtask

  task automatic test_ready_hold;
    bit ok;
    int n, g, a;
    beat_t exp, obs;
    logic [31:0] exp_stall;
    ready_mode = 2;
    do_start(2, 16);
    repeat (11) @(negedge clk);
    checks++;
    if ({rd_sel, abuf_rd_addr} !== {3'd0, 8'd8}) begin errors++; $display("FAIL t6_issue_halt_n10 got %h exp %h", {rd_sel, abuf_rd_addr}, {3'd0, 8'd8}); end
    repeat (9) @(negedge clk);
    checks++;
    if ({rd_sel, abuf_rd_addr} !== {3'd0, 8'd8}) begin errors++; $display("FAIL t6_issue_halt_n19 got %h exp %h", {rd_sel, abuf_rd_addr}, {3'd0, 8'd8}); end
    checks++;
    if ({out_valid, out_grp, out_data} !== {1'b1, 3'd0, mem_val(3'd0, 8'd0)}) begin
      errors++; $display("FAIL t6_hold_beat0 got %h exp %h", {out_valid, out_grp, out_data}, {1'b1, 3'd0, mem_val(3'd0, 8'd0)});
    end
    ready_mode = 0;
    wait_done(500, ok, n);
    checks++;
    if (!ok) begin errors++; $display("FAIL t6_done_timeout got 0 exp 1"); end
    checks++;
    if (q.size() != 32) begin errors++; $display("FAIL t6_count got %0d exp 32", q.size()); end
    for (int i = 0; i < 32; i++) begin
      g = i / 16; a = i % 16;
      exp = {mem_val(3'(g), 8'(a)), 3'(g), 1'(a == 15), 1'(a == 15 && g == 1)};
      obs = (i < q.size()) ? q[i] : 'x;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL t6_beat%0d got %h exp %h", i, obs, exp); end
    end
`ifdef PE_DRAIN_PERF_EN
    exp_stall = 32'(stalls);
`else
    exp_stall = '0;
`endif
    checks++;
    if (stall_cnt !== exp_stall) begin errors++; $display("FAIL t6_stall_cnt got %0d exp %0d", stall_cnt, exp_stall); end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    test_reset;
    test_single_group;
    test_full_sweep;
    test_backpressure;
    test_zero_count;
    test_reset_mid_drain;
    test_ready_hold;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
